// File: rtl/mfa_pkg.sv
// ---------------------------------------------------------------------------
// mfa_pkg
// Shared definitions for the MFA k-mer counting slice.
//   SYM_W        : bits per nucleotide symbol
//   addr_w(k)    : CGR memory address width for a k-mer of length k
//   cgr_state_t  : state encoding of the cgr_reader scan FSM
// ---------------------------------------------------------------------------
package mfa_pkg;

  localparam int SYM_W = 2;

  // One x bit and one y bit per symbol, so the address is SYM_W*k wide.
  function automatic int addr_w(input int k);
    return SYM_W * k;
  endfunction

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ISSUE   = 3'd1,
    S_CAPTURE = 3'd2,
    S_OUT     = 3'd3,
    S_FIN     = 3'd4
  } cgr_state_t;

endpackage

// File: rtl/cgr_decode.sv
// ---------------------------------------------------------------------------
// cgr_decode
// Purely combinational reorder of a CGR address {x, y} into its k-mer.
// Symbol of age i (0 = newest) is {x[K-1-i], y[K-1-i]} and lands in
// o_kmer[2i+1:2i], so the oldest symbol ends up in the MSBs.
//   i_addr : CGR address, x in the upper K bits, y in the lower K bits
//   o_kmer : decoded k-mer
// ---------------------------------------------------------------------------
module cgr_decode
  import mfa_pkg::*;
#(
  parameter int DATA_LEN = 3
) (
  input  logic [2*DATA_LEN-1:0] i_addr,
  output logic [2*DATA_LEN-1:0] o_kmer
);

  for (genvar i = 0; i < DATA_LEN; i++) begin : g_sym
    assign o_kmer[SYM_W*i+1] = i_addr[2*DATA_LEN-1-i];
    assign o_kmer[SYM_W*i]   = i_addr[DATA_LEN-1-i];
  end

endmodule

// File: rtl/cgr_reader.sv
// ---------------------------------------------------------------------------
// cgr_reader
// Scans the whole CGR count memory in ascending address order, absorbs the
// 1-cycle read latency, decodes each address into its k-mer and streams
// (address, k-mer, count) records downstream. Zero counts may be skipped.
//   CLK, RST     : clock, asynchronous active-high reset
//   start        : begin a scan (honoured only in IDLE)
//   skip_zero    : drop zero-count records (latched at start)
//   mem_ren/addr : memory read request, mem_rdata valid one cycle later
//   out_valid/out_ready/out_addr/out_kmer/out_count : record stream
//   busy         : FSM not in IDLE
//   done         : one-cycle pulse at scan end
//
// Handshake: a record transfers on a cycle where out_valid && out_ready.
// Once out_valid rises, it and the payload stay constant until transfer.
// ---------------------------------------------------------------------------
module cgr_reader
  import mfa_pkg::*;
#(
  parameter int DATA_LEN = 3,
  parameter int CNT_W    = 16
) (
  input  logic                        CLK,
  input  logic                        RST,
  input  logic                        start,
  input  logic                        skip_zero,
  output logic                        mem_ren,
  output logic [2*DATA_LEN-1:0]       mem_addr,
  input  logic [CNT_W-1:0]            mem_rdata,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [2*DATA_LEN-1:0]       out_addr,
  output logic [2*DATA_LEN-1:0]       out_kmer,
  output logic [CNT_W-1:0]            out_count,
  output logic                        busy,
  output logic                        done
);

  localparam int AW = addr_w(DATA_LEN);
  localparam int IW = AW + 1;
  // One extra index bit so the increment past the last entry never wraps.
  localparam logic [IW-1:0] LAST_IDX = {1'b0, {AW{1'b1}}};

  cgr_state_t          r_state;
  cgr_state_t          w_next;
  logic [IW-1:0]       r_idx;
  logic                r_skip;
  logic [AW-1:0]       r_out_addr;
  logic [AW-1:0]       r_out_kmer;
  logic [CNT_W-1:0]    r_out_count;
  logic [AW-1:0]       w_kmer;
  logic                w_scan_init;
  logic                w_idx_inc;
  logic                w_last;

  cgr_decode #(.DATA_LEN(DATA_LEN)) u_decode (
    .i_addr (r_idx[AW-1:0]),
    .o_kmer (w_kmer)
  );

  assign w_last = (r_idx == LAST_IDX);

  always_comb begin
    w_next      = r_state;
    w_scan_init = 1'b0;
    w_idx_inc   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_next      = S_ISSUE;
          w_scan_init = 1'b1;
        end
      end
      S_ISSUE: w_next = S_CAPTURE;
      S_CAPTURE: begin
        if (r_skip && (mem_rdata == '0)) begin
          if (w_last) begin
            w_next = S_FIN;
          end else begin
            w_next    = S_ISSUE;
            w_idx_inc = 1'b1;
          end
        end else begin
          w_next = S_OUT;
        end
      end
      S_OUT: begin
        if (out_ready) begin
          if (w_last) begin
            w_next = S_FIN;
          end else begin
            w_next    = S_ISSUE;
            w_idx_inc = 1'b1;
          end
        end
      end
      S_FIN:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state     <= S_IDLE;
      r_idx       <= '0;
      r_skip      <= 1'b0;
      r_out_addr  <= '0;
      r_out_kmer  <= '0;
      r_out_count <= '0;
    end else begin
      r_state <= w_next;
      if (w_scan_init) begin
        r_idx  <= '0;
        r_skip <= skip_zero;
      end else if (w_idx_inc) begin
        r_idx <= r_idx + 1'b1;
      end
      // Payload is loaded only in CAPTURE, which keeps it frozen during OUT.
      if (r_state == S_CAPTURE) begin
        r_out_addr  <= r_idx[AW-1:0];
        r_out_kmer  <= w_kmer;
        r_out_count <= mem_rdata;
      end
    end
  end

  // Read request is a pure decode of the state: one read per ISSUE visit.
  assign mem_ren   = (r_state == S_ISSUE);
  assign mem_addr  = (r_state == S_ISSUE) ? r_idx[AW-1:0] : '0;
  assign out_valid = (r_state == S_OUT);
  assign out_addr  = r_out_addr;
  assign out_kmer  = r_out_kmer;
  assign out_count = r_out_count;
  assign busy      = (r_state != S_IDLE);
  assign done      = (r_state == S_FIN);

endmodule

// File: tb/tb_cgr_reader.sv
// ---------------------------------------------------------------------------
// tb_cgr_reader
// Bench for cgr_reader (K=3, 16-bit counts) with a behavioural count memory
// and an expected-record queue checked on every handshake.
// ---------------------------------------------------------------------------
module tb_cgr_reader;

  localparam int K  = 3;
  localparam int AW = 2 * K;
  localparam int CW = 16;
  localparam int W  = AW + AW + CW;
  localparam int N  = 1 << AW;

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic          start = 1'b0;
  logic          skip_zero = 1'b0;
  logic          mem_ren;
  logic [AW-1:0] mem_addr;
  logic [CW-1:0] mem_rdata = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [AW-1:0] out_addr;
  logic [AW-1:0] out_kmer;
  logic [CW-1:0] out_count;
  logic          busy;
  logic          done;

  logic [CW-1:0] mem [0:N-1];
  logic [W-1:0]  exp_q[$];
  logic [AW-1:0] rec_kmer [0:N-1];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int t_start = 0;
  int rec_cnt, valid_cnt, ren_cnt, busy_cnt, done_cnt, done_rel;
  int last_hs, last_hs_rel, spacing_bad;

  cgr_reader #(.DATA_LEN(K), .CNT_W(CW)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .start     (start),
    .skip_zero (skip_zero),
    .mem_ren   (mem_ren),
    .mem_addr  (mem_addr),
    .mem_rdata (mem_rdata),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_addr  (out_addr),
    .out_kmer  (out_kmer),
    .out_count (out_count),
    .busy      (busy),
    .done      (done)
  );

  // ---------------- clock / reset / memory ----------------
  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc++;
  always @(posedge CLK) if (mem_ren) mem_rdata <= mem[mem_addr];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Independent k-mer model: symbol of age i = {x[K-1-i], y[K-1-i]}.
  function automatic logic [AW-1:0] model_kmer(input logic [AW-1:0] a);
    logic [AW-1:0] k;
    k = '0;
    for (int i = 0; i < K; i++) begin
      k[2*i+1] = a[2*K-1-i];
      k[2*i]   = a[K-1-i];
    end
    return k;
  endfunction

  function automatic logic [W-1:0] rec_of(input int a);
    logic [AW-1:0] aa;
    aa = AW'(a);
    return {aa, model_kmer(aa), mem[a]};
  endfunction

  // ---------------- monitor / scoreboard ----------------
  always @(negedge CLK) begin
    if (!RST) begin
      if (out_valid) valid_cnt++;
      if (mem_ren)   ren_cnt++;
      if (busy)      busy_cnt++;
      if (done) begin
        done_cnt++;
        done_rel = cyc - t_start;
      end
      if (out_valid && out_ready) begin
        logic [W-1:0] got;
        logic [W-1:0] want;
        got = {out_addr, out_kmer, out_count};
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL record_unexpected: got addr=%0d kmer=%b count=%0d, queue empty",
                   out_addr, out_kmer, out_count);
        end else begin
          want = exp_q.pop_front();
          if (got !== want) begin
            errors++;
            $display("FAIL record: got addr=%0d kmer=%b count=%0d, want addr=%0d kmer=%b count=%0d",
                     got[W-1 -: AW], got[CW +: AW], got[CW-1:0],
                     want[W-1 -: AW], want[CW +: AW], want[CW-1:0]);
          end
        end
        rec_kmer[out_addr] = out_kmer;
        rec_cnt++;
        if (rec_cnt > 1 && (cyc - last_hs) != 3) spacing_bad++;
        last_hs     = cyc;
        last_hs_rel = cyc - t_start;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic clear_stats();
    exp_q.delete();
    rec_cnt = 0; valid_cnt = 0; ren_cnt = 0; busy_cnt = 0;
    done_cnt = 0; done_rel = -1; last_hs = 0; last_hs_rel = -1; spacing_bad = 0;
  endtask

  task automatic fill_mem(input int mode);
    // mode 0: mem[a]=a, 1: only 5 and 42 nonzero, 2: all zero, 3: a+100
    for (int a = 0; a < N; a++) begin
      case (mode)
        0: mem[a] = CW'(a);
        1: mem[a] = (a == 5) ? 16'd7 : ((a == 42) ? 16'd1 : 16'd0);
        3: mem[a] = CW'(a + 100);
        default: mem[a] = '0;
      endcase
    end
  endtask

  task automatic push_expected(input logic skip);
    for (int a = 0; a < N; a++)
      if (!skip || mem[a] != 0) exp_q.push_back(rec_of(a));
  endtask

  // Start pulse; skip_zero is flipped afterwards, which must not matter.
  task automatic do_start(input logic skip);
    @(posedge CLK); #1;
    start = 1'b1; skip_zero = skip; t_start = cyc;
    @(posedge CLK); #1;
    start = 1'b0; skip_zero = ~skip;
  endtask

  task automatic wait_done(input int max_cyc);
    int n = 0;
    while (done_cnt == 0 && n < max_cyc) begin
      @(negedge CLK); n++;
    end
    checks++;
    if (done_cnt == 0) begin
      errors++;
      $display("FAIL done_timeout: no done within %0d cycles", max_cyc);
    end
    repeat (3) @(negedge CLK);
  endtask

  task automatic check_int(input string name, input int got, input int want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0d, want %0d", name, got, want);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    RST = 1'b1;
    repeat (3) @(negedge CLK);
    checks++;
    if ({mem_ren, mem_addr, out_valid, out_addr, out_kmer, out_count, busy, done} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got ren=%b maddr=%0d vld=%b addr=%0d kmer=%0d cnt=%0d busy=%b done=%b, want all 0",
               mem_ren, mem_addr, out_valid, out_addr, out_kmer, out_count, busy, done);
    end
    @(posedge CLK); #1;
    RST = 1'b0;
  endtask

  task automatic test_full_scan();
    clear_stats();
    fill_mem(0);
    out_ready = 1'b1;
    push_expected(1'b0);
    do_start(1'b0);
    wait_done(400);
    check_int("full_records", rec_cnt, 64);
    check_int("full_spacing_bad", spacing_bad, 0);
    check_int("full_done_count", done_cnt, 1);
    check_int("full_last_hs_rel", last_hs_rel, 192);
    check_int("full_done_rel", done_rel, 193);
    check_int("full_busy_cycles", busy_cnt, 193);
    check_int("full_mem_reads", ren_cnt, 64);
    check_int("full_queue_left", exp_q.size(), 0);
  endtask

  task automatic test_decode();
    check_int("decode_43", int'(rec_kmer[43]), int'(6'b110110));
    check_int("decode_36", int'(rec_kmer[36]), int'(6'b000011));
    check_int("decode_0",  int'(rec_kmer[0]),  0);
    check_int("decode_63", int'(rec_kmer[63]), int'(6'b111111));
  endtask

  task automatic test_skip_zero();
    clear_stats();
    fill_mem(1);
    push_expected(1'b1);
    do_start(1'b1);
    wait_done(400);
    check_int("skip_records", rec_cnt, 2);
    check_int("skip_mem_reads", ren_cnt, 64);
    check_int("skip_done_count", done_cnt, 1);
    check_int("skip_done_rel", done_rel, 131);
    check_int("skip_queue_left", exp_q.size(), 0);
  endtask

  task automatic test_backpressure();
    int  stall = 0;
    int  n = 0;
    logic want_next = 1'b0;
    logic [W-1:0] held;
    clear_stats();
    fill_mem(3);
    push_expected(1'b0);
    held = rec_of(10);
    do_start(1'b0);
    while (done_cnt == 0 && n < 600) begin
      @(posedge CLK); #1;
      if (stall < 4 && out_valid && out_addr == 6'd10) begin
        out_ready = 1'b0; stall++;
      end else begin
        out_ready = 1'b1;
      end
      @(negedge CLK);
      n++;
      if (want_next) begin
        want_next = 1'b0;
        checks++;
        if (mem_ren !== 1'b1 || mem_addr !== 6'd11) begin
          errors++;
          $display("FAIL bp_next_read: got ren=%b addr=%0d, want ren=1 addr=11", mem_ren, mem_addr);
        end
      end
      if (!out_ready) begin
        checks++;
        if (out_valid !== 1'b1 || {out_addr, out_kmer, out_count} !== held || mem_ren !== 1'b0) begin
          errors++;
          $display("FAIL bp_stall: got vld=%b addr=%0d kmer=%b cnt=%0d ren=%b, want vld=1 addr=10 kmer=%b cnt=%0d ren=0",
                   out_valid, out_addr, out_kmer, out_count, mem_ren, held[CW +: AW], held[CW-1:0]);
        end
      end else if (out_valid && out_addr == 6'd10 && stall == 4) begin
        want_next = 1'b1;
      end
    end
    repeat (3) @(negedge CLK);
    check_int("bp_stall_cycles", stall, 4);
    check_int("bp_records", rec_cnt, 64);
    check_int("bp_done_count", done_cnt, 1);
    check_int("bp_done_rel", done_rel, 197);
  endtask

  task automatic test_start_hygiene();
    int   n = 0;
    logic restarted = 1'b0;
    logic hit = 1'b0;
    clear_stats();
    fill_mem(0);
    out_ready = 1'b1;
    for (int a = 0; a < 30; a++) exp_q.push_back(rec_of(a));
    do_start(1'b0);
    while (!hit && n < 400) begin
      @(posedge CLK); #1;
      n++;
      if (out_valid && out_addr == 6'd20 && !restarted) begin
        start = 1'b1; restarted = 1'b1;
      end else begin
        start = 1'b0;
      end
      if (out_valid && out_addr == 6'd30) begin
        hit = 1'b1;
        out_ready = 1'b0;
        RST = 1'b1;
        #1;
        checks++;
        if ({mem_ren, mem_addr, out_valid, out_addr, out_kmer, out_count, busy, done} !== '0) begin
          errors++;
          $display("FAIL midscan_reset: got ren=%b maddr=%0d vld=%b addr=%0d kmer=%0d cnt=%0d busy=%b done=%b, want all 0",
                   mem_ren, mem_addr, out_valid, out_addr, out_kmer, out_count, busy, done);
        end
      end
    end
    check_int("hyg_reached_rec30", int'(hit), 1);
    start = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    RST = 1'b0;
    out_ready = 1'b1;
    repeat (5) @(negedge CLK);
    check_int("hyg_records", rec_cnt, 30);
    check_int("hyg_no_done", done_cnt, 0);
    check_int("hyg_queue_left", exp_q.size(), 0);
    check_int("hyg_idle_after_reset", int'(busy), 0);
    // Fresh scan after the abort must start again from address 0.
    test_full_scan();
  endtask

  task automatic test_all_zero();
    clear_stats();
    fill_mem(2);
    do_start(1'b1);
    wait_done(400);
    check_int("zero_valid_cycles", valid_cnt, 0);
    check_int("zero_done_count", done_cnt, 1);
    check_int("zero_done_rel", done_rel, 129);
    check_int("zero_mem_reads", ren_cnt, 64);
  endtask

  initial begin
    clear_stats();
    fill_mem(2);
    test_reset();
    test_full_scan();
    test_decode();
    test_skip_zero();
    test_backpressure();
    test_start_hygiene();
    test_all_zero();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cgr_reader.md
Name: cgr_reader

Overview:
- Read-side counterpart of the CGR address generator.
- Scans every entry of the CGR k-mer count memory in ascending address order.
- Absorbs the memory's 1-cycle read latency and decodes each address back into its K-symbol k-mer.
- Streams (address, k-mer, count) records over a valid/ready interface to downstream MFA logic; zero-count entries can optionally be skipped.

Parameters:
- DATA_LEN, 3: k-mer length K. Memory address width is 2*DATA_LEN.
- CNT_W, 16: count word width.

Ports:
- CLK  input  1  clock
- RST  input  1  reset, asynchronous, active-high
- start  input  1  begin a full scan; sampled only in IDLE
- skip_zero  input  1  suppress records whose count is 0; sampled at start
- mem_ren  output  1  memory read enable
- mem_addr  output  2*DATA_LEN  memory read address
- mem_rdata  input  CNT_W  read data, valid the cycle after mem_ren
- out_valid  output  1  record valid
- out_ready  input  1  downstream accepts the record
- out_addr  output  2*DATA_LEN  raw CGR address of the record
- out_kmer  output  2*DATA_LEN  decoded k-mer, oldest symbol in the MSBs
- out_count  output  CNT_W  count for the record
- busy  output  1  high whenever the FSM is not in IDLE
- done  output  1  one-cycle pulse at scan end

Behaviour:
- Reset: state IDLE, idx=0, skip flag=0. All outputs are 0: mem_ren, mem_addr, out_valid, out_addr, out_kmer, out_count, busy, done.
- Address layout: addr = {x, y}, with x = addr[2K-1:K] and y = addr[K-1:0].
- Symbol of age i (i=0 newest) = {x[K-1-i], y[K-1-i]}.
- out_kmer[2i+1:2i] = symbol of age i. Example, K=3: addr 6'b101011 gives out_kmer 6'b110110.
- FSM states: IDLE, ISSUE, CAPTURE, OUT, FIN.
- IDLE:
  - On start=1: idx<=0, latch skip_zero, go to ISSUE.
  - Otherwise stay.
- ISSUE: mem_ren=1 and mem_addr=idx, both registered-output-free, i.e. combinational from state. Go to CAPTURE.
- CAPTURE:
  - Register mem_rdata into out_count, idx into out_addr, and decode(idx) into out_kmer.
  - If the skip flag is set and mem_rdata==0:
    - if idx is the last index, go to FIN;
    - otherwise idx<=idx+1 and go to ISSUE.
  - Otherwise go to OUT.
- OUT:
  - out_valid=1. out_addr, out_kmer and out_count are held stable until out_ready=1.
  - On handshake: if idx is the last index go to FIN, else idx<=idx+1 and go to ISSUE.
- FIN: done=1 for exactly one cycle, then IDLE.
- Last index is 2^(2K)-1. idx is 2K+1 bits wide, so the final increment never wraps mid-scan.
- Throughput is 3 cycles per emitted record with out_ready held high, and 2 cycles per skipped record.
- out_valid never drops without a handshake.
- start while busy=1 is ignored; the scan is not restarted.
- start in the same cycle as the done pulse is ignored; it is honoured from IDLE on the following cycle.
- Changing skip_zero mid-scan has no effect.
- Asserting RST mid-scan immediately returns the block to reset state. A record held in OUT is dropped and no done pulse is produced.
- Exactly one memory read is outstanding at any time. mem_ren is never asserted in CAPTURE, OUT, FIN or IDLE.
- If every entry is skipped, the block emits no records and still pulses done once.

Decomposition:
- Package mfa_pkg holds:
  - SYM_W=2;
  - the cgr_reader state encoding (IDLE/ISSUE/CAPTURE/OUT/FIN);
  - the ADDR_W = 2*DATA_LEN helper.
- Sub-module cgr_decode: purely combinational addr -> k-mer reorder, parameterised by DATA_LEN. It is reusable by the testbench scoreboard and future k-mer consumers.

Test Plan:
- Full scan, K=3, memory[a]=a, out_ready=1, skip_zero=0 -> 64 records, addr 0..63 in order. Count equals addr. Records spaced 3 cycles apart. done pulses one cycle after the 64th handshake. busy spans start+1 through the FIN cycle.
- Decode check -> addr 6'b101011 gives out_kmer 6'b110110. addr 6'b100100 (writer reset value) gives 6'b000011. addr 0 gives 0. addr 63 gives 6'b111111.
- skip_zero=1, only memory[5]=7 and memory[42]=1 nonzero -> exactly two records, (5,7) then (42,1), then a single done pulse. mem_ren is asserted 64 times in total.
- Backpressure: out_ready low for 4 cycles on record addr 10 -> out_valid stays 1 and all payload bits stay constant. No mem_ren occurs during the stall. Next mem_addr=11 appears the cycle after the handshake.
- Reset and start hygiene: start pulsed again at record 20 -> ignored, with no restart. RST asserted while in OUT at record 30 -> all outputs 0 immediately and no done pulse. A new start then yields a clean scan from addr 0.
- All-zero memory with skip_zero=1 -> no out_valid at all. done pulses once, 128 cycles after start plus FIN.
